// File: rtl/stdp_pkg.sv
// stdp_pkg: shared widths, update magnitude, dt binning and update type for the STDP synapse
package stdp_pkg;
   localparam int WW_DEF    = 8;
   localparam int TW_DEF    = 4;
   localparam int A_MAX_DEF = 16;

   typedef enum logic [1:0] {UPD_NONE, UPD_LTP, UPD_LTD} upd_e;

   // Bins of four cycles each; magnitude halves per bin
   function automatic int unsigned dt_shift(input int unsigned dt);
      return (dt - 1) >> 2;
   endfunction
endpackage

// File: rtl/stdp_spike_timer.sv
// stdp_spike_timer: seen flag plus saturating age counter tracking the last spike of one source
module stdp_spike_timer #(
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          spike,
   input  logic          consume,
   output logic          seen,
   output logic [TW-1:0] age
);
   localparam logic [TW-1:0] WINDOW = '1;

   logic          seen_q, seen_d;
   logic [TW-1:0] age_q, age_d;

   always_comb begin
      seen_d = spike ? 1'b1 : consume ? 1'b0 : (seen_q && age_q == WINDOW) ? 1'b0 : seen_q;
      age_d  = spike ? TW'(1) : (seen_q && !consume && age_q != WINDOW) ? age_q + 1'b1 : age_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q <= 1'b0;
         age_q  <= '0;
      end else begin
         seen_q <= seen_d;
         age_q  <= age_d;
      end
   end

   assign seen = seen_q;
   assign age  = age_q;
endmodule

// File: rtl/stdp_synapse.sv
// stdp_synapse: pair-based STDP learning synapse with saturating weight and weighted psc output
module stdp_synapse
   import stdp_pkg::*;
#(
   parameter int WW     = WW_DEF,
   parameter int TW     = TW_DEF,
   parameter int W_INIT = 32,
   parameter int W_MAX  = 255,
   parameter int W_MIN  = 0,
   parameter int A_MAX  = A_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pre_spike,
   input  logic          post_spike,
   input  logic          learn_en,
   output logic [WW-1:0] weight,
   output logic [TW-1:0] time_diff,
   output logic [WW-1:0] psc,
   output logic          update_w_flag
);
   localparam logic [WW:0]   WMAX_X = (WW+1)'(W_MAX);
   localparam logic [WW:0]   WMIN_X = (WW+1)'(W_MIN);
   localparam logic [WW-1:0] WMAX_W = WW'(W_MAX);
   localparam logic [WW-1:0] WMIN_W = WW'(W_MIN);

   logic          pre_seen, post_seen;
   logic [TW-1:0] pre_age, post_age;
   upd_e          upd;
   logic [TW-1:0] dt;
   logic [WW:0]   delta, sum;
   logic [WW-1:0] w_up, w_dn;

   logic [WW-1:0] weight_q, weight_d, psc_q, psc_d;
   logic [TW-1:0] time_diff_q, time_diff_d;
   logic          update_w_flag_q, update_w_flag_d;

   stdp_spike_timer #(.TW(TW)) u_pre (
      .clk     (clk),
      .rst_n   (rst_n),
      .spike   (pre_spike),
      .consume (upd == UPD_LTP),
      .seen    (pre_seen),
      .age     (pre_age)
   );

   stdp_spike_timer #(.TW(TW)) u_post (
      .clk     (clk),
      .rst_n   (rst_n),
      .spike   (post_spike),
      .consume (upd == UPD_LTD),
      .seen    (post_seen),
      .age     (post_age)
   );

   // Pairs are consumed even with learning disabled so stale pairs never apply later
   always_comb begin
      upd = (post_spike && !pre_spike && pre_seen) ? UPD_LTP :
            (pre_spike && !post_spike && post_seen) ? UPD_LTD : UPD_NONE;
      dt = (upd == UPD_LTP) ? pre_age : post_age;
      delta = (WW+1)'(A_MAX >> dt_shift(int'(dt)));
      sum = {1'b0, weight_q} + delta;
      w_up = (sum > WMAX_X) ? WMAX_W : sum[WW-1:0];
      w_dn = ({1'b0, weight_q} < WMIN_X + delta) ? WMIN_W : weight_q - delta[WW-1:0];
      update_w_flag_d = learn_en && upd != UPD_NONE;
      weight_d = !update_w_flag_d ? weight_q : (upd == UPD_LTP) ? w_up : w_dn;
      time_diff_d = update_w_flag_d ? dt : time_diff_q;
      psc_d = pre_spike ? weight_q : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight_q        <= WW'(W_INIT);
         psc_q           <= '0;
         time_diff_q     <= '0;
         update_w_flag_q <= 1'b0;
      end else begin
         weight_q        <= weight_d;
         psc_q           <= psc_d;
         time_diff_q     <= time_diff_d;
         update_w_flag_q <= update_w_flag_d;
      end
   end

   assign weight        = weight_q;
   assign psc           = psc_q;
   assign time_diff     = time_diff_q;
   assign update_w_flag = update_w_flag_q;
endmodule
